// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: I2S (Philips) serial DAC transmitter clocked by the codec bit clock.
// Captures one signed left/right sample pair per frame on the falling word clock,
// shifts each word out MSB-first one bclk after the word clock changes, and keeps
// the data line muted until the word-clock framing has been verified.
// Optional feature macro: I2S_DAC_TX_ERRCNT_EN (saturating lock-loss counter on err_count).
module i2s_dac_tx #(
  parameter int BITSIZE = 16,
  parameter int SLOT    = 32
) (
  input  logic               bclk,
  input  logic               resetn,
  input  logic               lrclk,
  input  logic [BITSIZE-1:0] left_in,
  input  logic [BITSIZE-1:0] right_in,
  output logic               sample_req,
  output logic               dac_data,
  output logic               locked,
  output logic [7:0]         err_count
);

  localparam int CW = $clog2(SLOT + 1);
  localparam logic [CW-1:0] CNT_GOOD  = CW'(SLOT - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SLOT);
  localparam logic [CW-1:0] CNT_SHIFT = CW'(BITSIZE - 1);

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  logic               lrclk_q;
  logic [CW-1:0]      cnt;
  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic               good_prev;
  logic               good_prev_nx;
  logic [BITSIZE-1:0] rsh;
  logic [BITSIZE-1:0] sr;
  logic [BITSIZE-1:0] sr_nx;
  logic               bit_nx;
  logic               lr_edge;
  logic               left_start;
  logic               right_start;
  logic               good_period;
  logic               timeout;

  assign lr_edge     = (lrclk != lrclk_q);
  assign left_start  = lr_edge && !lrclk;
  assign right_start = lr_edge && lrclk;
  assign good_period = lr_edge && (cnt == CNT_GOOD);
  assign timeout     = !lr_edge && (cnt == CNT_MAX);

  // Word-clock history and half-frame length counter (saturates so a stuck lrclk is visible)
  always_ff @(posedge bclk) begin
    if (!resetn) begin
      lrclk_q <= 1'b0;
      cnt     <= '0;
    end else begin
      lrclk_q <= lrclk;
      if (lr_edge)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
    end
  end

  // Lock tracking: good_prev remembers that the right half-frame just finished at the
  // nominal length; a left-start edge that also closes a nominal half-frame then locks
  always_comb begin
    state_nx     = state;
    good_prev_nx = good_prev;
    case (state)
      ST_WAIT: begin
        if (left_start) begin
          state_nx     = ST_ACQ;
          good_prev_nx = 1'b0;
        end
      end
      ST_ACQ: begin
        if (timeout) begin
          good_prev_nx = 1'b0;
        end else if (right_start) begin
          good_prev_nx = good_period;
        end else if (left_start) begin
          if (good_period && good_prev)
            state_nx = ST_LOCK;
          good_prev_nx = 1'b0;
        end
      end
      ST_LOCK: begin
        if (timeout || (lr_edge && !good_period)) begin
          state_nx     = ST_ACQ;
          good_prev_nx = 1'b0;
        end
      end
      default: begin
        state_nx     = ST_WAIT;
        good_prev_nx = 1'b0;
      end
    endcase
  end

  // Framing state register; locked mirrors the state so it drops on the offending edge
  always_ff @(posedge bclk) begin
    if (!resetn) begin
      state     <= ST_WAIT;
      good_prev <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nx;
      good_prev <= good_prev_nx;
      locked    <= (state_nx == ST_LOCK);
    end
  end

  // Both channels are captured on the left-start edge so a pair never straddles frames;
  // the left word goes straight into the shifter, so only the right word needs a shadow
  always_ff @(posedge bclk) begin
    if (!resetn) begin
      rsh        <= '0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= left_start;
      if (left_start)
        rsh <= right_in;
    end
  end

  // Next serial bit: MSB on the edge cycle itself, then the remaining bits, then zeros
  always_comb begin
    sr_nx  = sr;
    bit_nx = 1'b0;
    if (left_start) begin
      sr_nx  = left_in;
      bit_nx = left_in[BITSIZE-1];
    end else if (right_start) begin
      sr_nx  = rsh;
      bit_nx = rsh[BITSIZE-1];
    end else if (cnt < CNT_SHIFT) begin
      bit_nx = sr[BITSIZE-2];
      sr_nx  = sr << 1;
    end
  end

  // Shift register and muted data line; anything but a verified lock transmits silence
  always_ff @(posedge bclk) begin
    if (!resetn) begin
      sr       <= '0;
      dac_data <= 1'b0;
    end else begin
      sr       <= sr_nx;
      dac_data <= (state_nx == ST_LOCK) && bit_nx;
    end
  end

`ifdef I2S_DAC_TX_ERRCNT_EN
  logic lose_lock;
  assign lose_lock = (state == ST_LOCK) && (state_nx != ST_LOCK);

  // Lock-loss counter, held at 255 and cleared only by reset
  always_ff @(posedge bclk) begin
    if (!resetn)
      err_count <= 8'd0;
    else if (lose_lock && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: self-checking bench for i2s_dac_tx. A behavioural model built on
// edge timestamps predicts every output each cycle; fixed vectors and hand-written
// sequences pin down the reset state, word contents and lock/unlock corner cases.
module tb_i2s_dac_tx;

  localparam int BITSIZE = 16;
  localparam int SLOT    = 32;

`ifdef I2S_DAC_TX_ERRCNT_EN
  localparam int ERRCNT = 1;
`else
  localparam int ERRCNT = 0;
`endif

  logic               bclk = 1'b0;
  logic               resetn;
  logic               lrclk;
  logic [BITSIZE-1:0] left_in;
  logic [BITSIZE-1:0] right_in;
  logic               sample_req;
  logic               dac_data;
  logic               locked;
  logic [7:0]         err_count;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0=wait 1=acquire 2=locked; times are in bclk cycles
  int                 mMode;
  logic               mPrev;
  longint             mT, mE1, mE2, mAcqSince;
  logic [BITSIZE-1:0] mWord, mRsh;
  int                 mErr;
  logic               mReq;

  typedef struct {
    logic               rn;
    logic               lr;
    logic [BITSIZE-1:0] l;
    logic [BITSIZE-1:0] r;
    logic               expReq;
    logic               expDac;
    logic               expLocked;
    logic [7:0]         expErr;
  } vec_t;

  vec_t vecs[5];

  i2s_dac_tx #(.BITSIZE(BITSIZE), .SLOT(SLOT)) dut (
    .bclk      (bclk),
    .resetn    (resetn),
    .lrclk     (lrclk),
    .left_in   (left_in),
    .right_in  (right_in),
    .sample_req(sample_req),
    .dac_data  (dac_data),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 bclk = ~bclk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic loseLock();
    mMode     = 1;
    mAcqSince = mT;
`ifdef I2S_DAC_TX_ERRCNT_EN
    if (mErr < 255) mErr++;
`endif
  endtask

  // Advance the model by one bclk using the values the DUT just sampled
  task automatic modelStep(input logic rn, input logic lr, input logic [BITSIZE-1:0] l, input logic [BITSIZE-1:0] r);
    logic   isEdge, isLeft;
    longint period;
    mT++;
    if (!rn) begin
      mMode = 0; mPrev = 1'b0; mE1 = mT; mE2 = mT; mAcqSince = mT;
      mWord = '0; mRsh = '0; mErr = 0; mReq = 1'b0;
      return;
    end
    isEdge = (lr != mPrev);
    isLeft = isEdge && !lr;
    mPrev  = lr;
    mReq   = isLeft;
    if (isEdge) begin
      period = mT - mE1;
      case (mMode)
        0: if (isLeft) begin mMode = 1; mAcqSince = mT; end
        1: if (isLeft && period == SLOT && (mE1 - mE2) == SLOT && mAcqSince < mE1) mMode = 2;
        default: if (period != SLOT) loseLock();
      endcase
      mE2 = mE1;
      mE1 = mT;
      if (isLeft) begin
        mRsh  = r;
        mWord = l;
      end else begin
        mWord = mRsh;
      end
    end else if (mMode == 2 && (mT - mE1) > SLOT) begin
      loseLock();
    end
  endtask

  task automatic checkModel();
    longint k;
    logic   expDac;
    k = mT - mE1;
    expDac = 1'b0;
    if (mMode == 2 && k < BITSIZE) expDac = mWord[BITSIZE-1-int'(k)];
    checkOutput("sample_req", {31'd0, sample_req}, {31'd0, mReq});
    checkOutput("dac_data", {31'd0, dac_data}, {31'd0, expDac});
    checkOutput("locked", {31'd0, locked}, (mMode == 2) ? 32'd1 : 32'd0);
    checkOutput("err_count", {24'd0, err_count}, mErr);
  endtask

  task automatic applyStimulus(input logic rn, input logic lr, input logic [BITSIZE-1:0] l, input logic [BITSIZE-1:0] r);
    @(negedge bclk);
    resetn = rn; lrclk = lr; left_in = l; right_in = r;
    @(posedge bclk);
    modelStep(rn, lr, l, r);
    #1;
    checkModel();
  endtask

  // One half-frame of len cycles at the given level; collects the first word's bits
  task automatic runHalf(input logic lr, input int len, input logic [BITSIZE-1:0] l,
                         input logic [BITSIZE-1:0] r, output logic [BITSIZE-1:0] bits);
    bits = '0;
    for (int i = 0; i < len; i++) begin
      applyStimulus(1'b1, lr, l, r);
      if (i < BITSIZE) bits = {bits[BITSIZE-2:0], dac_data};
    end
  endtask

  initial begin
    logic [BITSIZE-1:0] b;
    int reqCount;
    int len, sel;
    logic lvl;
    logic [BITSIZE-1:0] rl, rr;

    resetn = 1'b0; lrclk = 1'b0; left_in = '0; right_in = '0;
    mT = 0;
    modelStep(1'b0, 1'b0, '0, '0);

    vecs[0] = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 16'h8001, 16'h7FFE, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{1'b1, 1'b0, 16'h8001, 16'h7FFE, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 16'h8001, 16'h7FFE, 1'b0, 1'b0, 1'b0, 8'd0};

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].rn, vecs[i].lr, vecs[i].l, vecs[i].r);
      checkOutput("vec sample_req", {31'd0, sample_req}, {31'd0, vecs[i].expReq});
      checkOutput("vec dac_data", {31'd0, dac_data}, {31'd0, vecs[i].expDac});
      checkOutput("vec locked", {31'd0, locked}, {31'd0, vecs[i].expLocked});
      checkOutput("vec err_count", {24'd0, err_count}, {24'd0, vecs[i].expErr});
    end

    // Nominal framing: rising edge ignored in wait, lock at the second left-start edge
    runHalf(1'b0, 30, 16'h8001, 16'h7FFE, b);
    runHalf(1'b1, 32, 16'h8001, 16'h7FFE, b);
    runHalf(1'b0, 32, 16'h8001, 16'h7FFE, b);
    checkOutput("not locked after 1st left edge", {31'd0, locked}, 32'd0);
    runHalf(1'b1, 32, 16'h8001, 16'h7FFE, b);
    runHalf(1'b0, 32, 16'h8001, 16'h7FFE, b);
    checkOutput("left word 8001", {16'd0, b}, 32'h8001);
    checkOutput("locked nominal", {31'd0, locked}, 32'd1);
    runHalf(1'b1, 32, 16'h8001, 16'h7FFE, b);
    checkOutput("right word 7FFE", {16'd0, b}, 32'h7FFE);

    // Input changes mid half-frame only take effect at the next left-start edge
    runHalf(1'b0, 32, 16'h8001, 16'h7FFE, b);
    checkOutput("left word again", {16'd0, b}, 32'h8001);
    runHalf(1'b1, 16, 16'h8001, 16'h7FFE, b);
    checkOutput("right word before change", {16'd0, b}, 32'h7FFE);
    runHalf(1'b1, 16, 16'h1234, 16'h7FFE, b);
    runHalf(1'b0, 32, 16'h1234, 16'h7FFE, b);
    checkOutput("left word 1234", {16'd0, b}, 32'h1234);
    runHalf(1'b1, 32, 16'h1234, 16'h5555, b);
    checkOutput("right word held", {16'd0, b}, 32'h7FFE);
    runHalf(1'b0, 32, 16'h1234, 16'h5555, b);
    runHalf(1'b1, 32, 16'h1234, 16'h5555, b);
    checkOutput("right word 5555", {16'd0, b}, 32'h5555);

    // Short half-frame drops lock on the early edge; two good halves re-lock
    runHalf(1'b0, 20, 16'h1234, 16'h5555, b);
    runHalf(1'b1, 32, 16'h1234, 16'h5555, b);
    checkOutput("unlocked after short half", {31'd0, locked}, 32'd0);
    checkOutput("muted after short half", {16'd0, b}, 32'd0);
    checkOutput("err after short half", {24'd0, err_count}, ERRCNT);
    runHalf(1'b0, 32, 16'h1234, 16'h5555, b);
    runHalf(1'b1, 32, 16'h1234, 16'h5555, b);
    runHalf(1'b0, 32, 16'h1234, 16'h5555, b);
    checkOutput("relocked", {31'd0, locked}, 32'd1);
    checkOutput("relock word", {16'd0, b}, 32'h1234);

    // Stuck word clock times out after the counter saturates
    runHalf(1'b1, 32, 16'h1234, 16'h5555, b);
    runHalf(1'b0, 40, 16'h1234, 16'h5555, b);
    checkOutput("unlocked after timeout", {31'd0, locked}, 32'd0);
    checkOutput("err after timeout", {24'd0, err_count}, 2 * ERRCNT);

    // Repeated forced losses saturate the counter
    runHalf(1'b1, 32, 16'h1234, 16'h5555, b);
    for (int i = 0; i < 300; i++) begin
      rl = 16'($urandom); rr = 16'($urandom);
      runHalf(1'b0, 32, rl, rr, b);
      runHalf(1'b1, 32, rl, rr, b);
      runHalf(1'b0, 10, rl, rr, b);
      runHalf(1'b1, 5, rl, rr, b);
    end
    checkOutput("err saturated", {24'd0, err_count}, 255 * ERRCNT);

    // Randomised half-frame lengths and data against the model
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      len = (sel < 6) ? 32 : (sel == 6) ? 31 : (sel == 7) ? 33 : (sel == 8) ? 20 : 40;
      lvl = ~lrclk;
      runHalf(lvl, len, 16'($urandom), 16'($urandom), b);
    end

    // Reset in the middle of a locked left word
    if (lrclk == 1'b0) runHalf(1'b1, 32, 16'hA5C3, 16'h3C5A, b);
    runHalf(1'b0, 32, 16'hA5C3, 16'h3C5A, b);
    runHalf(1'b1, 32, 16'hA5C3, 16'h3C5A, b);
    runHalf(1'b0, 32, 16'hA5C3, 16'h3C5A, b);
    runHalf(1'b1, 32, 16'hA5C3, 16'h3C5A, b);
    checkOutput("locked before reset", {31'd0, locked}, 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    checkOutput("reset dac_data", {31'd0, dac_data}, 32'd0);
    checkOutput("reset locked", {31'd0, locked}, 32'd0);
    checkOutput("reset sample_req", {31'd0, sample_req}, 32'd0);
    checkOutput("reset err_count", {24'd0, err_count}, 32'd0);
    reqCount = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
      reqCount += int'(sample_req);
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
      reqCount += int'(sample_req);
    end
    checkOutput("no req after reset", reqCount, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    checkOutput("req on falling lrclk", {31'd0, sample_req}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
